// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant and an
// optional cap on how many consecutive cycles a single grant may be held.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant held; arbitrate among req using ptr search order
// ST_GRANT | one grant held; watch owner's req and the hold counter
module rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id,
    output logic       timeout
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LP_HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic       LP_LIMIT_EN   = (MAX_HOLD != 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic       r_gnt_valid;
    logic       w_gnt_valid_nxt;
    logic [1:0] r_gnt_id;
    logic [1:0] w_gnt_id_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;

    logic       w_pick_found;
    logic [1:0] w_pick_id;
    logic       w_release;
    logic       w_limit;

    // Walk the search order from lowest to highest priority so the last hit
    // (ptr itself) wins.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[r_ptr - 2'(k)]) begin
                w_pick_found = 1'b1;
                w_pick_id    = r_ptr - 2'(k);
            end
        end
    end

    assign w_release = ~req[r_gnt_id];
    assign w_limit   = LP_LIMIT_EN && (r_cnt == LP_HOLD_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 2'd3;
            r_cnt       <= 8'd0;
            r_gnt       <= 4'b0000;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= 2'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_valid_nxt = r_gnt_valid;
        w_gnt_id_nxt    = r_gnt_id;
        w_timeout_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt     = ST_GRANT;
                    w_gnt_nxt       = 4'b0001 << w_pick_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_gnt_id_nxt    = w_pick_id;
                    w_cnt_nxt       = 8'd1;
                end
            end
            ST_GRANT: begin
                if (w_release || w_limit) begin
                    // Owner drops to lowest priority; a release masks a
                    // coincident limit hit.
                    w_state_nxt     = ST_IDLE;
                    w_gnt_nxt       = 4'b0000;
                    w_gnt_valid_nxt = 1'b0;
                    w_gnt_id_nxt    = 2'd0;
                    w_cnt_nxt       = 8'd0;
                    w_ptr_nxt       = r_gnt_id - 2'd1;
                    w_timeout_nxt   = ~w_release;
                end else if (r_cnt != 8'hFF) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_gnt_nxt       = 4'b0000;
                w_gnt_valid_nxt = 1'b0;
                w_gnt_id_nxt    = 2'd0;
                w_cnt_nxt       = 8'd0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: four instances with different hold limits share one
// request stream and are checked every cycle against a behavioural model.
module tb_rr_arbiter;

    localparam int HOLD [4] = '{3, 0, 1, 255};

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_edge;

    logic [3:0] gnt_w  [4];
    logic       gval_w [4];
    logic [1:0] gid_w  [4];
    logic       to_w   [4];

    int total;
    int bad;

    rr_arbiter #(.MAX_HOLD(3)) u_h3 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_w[0]), .gnt_valid(gval_w[0]), .gnt_id(gid_w[0]), .timeout(to_w[0]));
    rr_arbiter #(.MAX_HOLD(0)) u_h0 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_w[1]), .gnt_valid(gval_w[1]), .gnt_id(gid_w[1]), .timeout(to_w[1]));
    rr_arbiter #(.MAX_HOLD(1)) u_h1 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_w[2]), .gnt_valid(gval_w[2]), .gnt_id(gid_w[2]), .timeout(to_w[2]));
    rr_arbiter #(.MAX_HOLD(255)) u_h255 (
        .clk(clk), .reset(reset), .req(req),
        .gnt(gnt_w[3]), .gnt_valid(gval_w[3]), .gnt_id(gid_w[3]), .timeout(to_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Model: who owns the resource, for how many cycles, and the priority pointer.
    int m_busy  [4];
    int m_owner [4];
    int m_ptr   [4];
    int m_held  [4];
    int m_to    [4];

    always @(posedge clk or posedge reset) begin
        int c;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_busy[i] = 0; m_owner[i] = 0; m_ptr[i] = 3; m_held[i] = 0; m_to[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_busy[i] != 0) begin
                    if (req[m_owner[i]] == 1'b0) begin
                        m_busy[i] = 0; m_to[i] = 0;
                        m_ptr[i] = (m_owner[i] + 3) % 4;
                    end else if (HOLD[i] != 0 && m_held[i] == HOLD[i]) begin
                        m_busy[i] = 0; m_to[i] = 1;
                        m_ptr[i] = (m_owner[i] + 3) % 4;
                    end else begin
                        m_to[i] = 0;
                        if (m_held[i] < 255) m_held[i] = m_held[i] + 1;
                    end
                end else begin
                    m_to[i] = 0;
                    for (int k = 0; k < 4; k++) begin
                        c = (m_ptr[i] - k + 4) % 4;
                        if (m_busy[i] == 0 && req[c] == 1'b1) begin
                            m_busy[i] = 1; m_owner[i] = c; m_held[i] = 1;
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) req_edge <= req;

    logic [3:0] prev_gnt [4];
    int         waits    [4][4];

    always @(negedge clk) begin
        logic [3:0] eg;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                prev_gnt[i] = 4'b0000;
                for (int j = 0; j < 4; j++) waits[i][j] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                eg = (m_busy[i] != 0) ? (4'b0001 << m_owner[i]) : 4'b0000;
                chk($sformatf("u%0d.gnt", i), int'(gnt_w[i]), int'(eg));
                chk($sformatf("u%0d.gnt_valid", i), int'(gval_w[i]), m_busy[i]);
                chk($sformatf("u%0d.gnt_id", i), int'(gid_w[i]), (m_busy[i] != 0) ? m_owner[i] : 0);
                chk($sformatf("u%0d.timeout", i), int'(to_w[i]), m_to[i]);
                chk($sformatf("u%0d.onehot", i), ($countones(gnt_w[i]) <= 1) ? 1 : 0, 1);
                chk($sformatf("u%0d.valid_consistent", i), int'(gval_w[i]), (gnt_w[i] != 4'b0000) ? 1 : 0);
                if (prev_gnt[i] != 4'b0000 && gnt_w[i] != 4'b0000)
                    chk($sformatf("u%0d.bubble", i), int'(gnt_w[i]), int'(prev_gnt[i]));
                if (prev_gnt[i] == 4'b0000 && gnt_w[i] != 4'b0000) begin
                    for (int j = 0; j < 4; j++) begin
                        if (j == int'(gid_w[i]))   waits[i][j] = 0;
                        else if (req_edge[j])      waits[i][j] = waits[i][j] + 1;
                        else                       waits[i][j] = 0;
                    end
                    for (int j = 0; j < 4; j++)
                        chk($sformatf("u%0d.fair%0d", i, j), (waits[i][j] <= 4) ? 1 : 0, 1);
                end else begin
                    for (int j = 0; j < 4; j++)
                        if (!req_edge[j]) waits[i][j] = 0;
                end
                prev_gnt[i] = gnt_w[i];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations on the MAX_HOLD=3 instance.
    task automatic lit(input string n, input logic [3:0] g, input int id, input logic to);
        chk({n, ".gnt"}, int'(gnt_w[0]), int'(g));
        chk({n, ".gnt_valid"}, int'(gval_w[0]), (g != 4'b0000) ? 1 : 0);
        chk({n, ".gnt_id"}, int'(gid_w[0]), id);
        chk({n, ".timeout"}, int'(to_w[0]), int'(to));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        req   = 4'b0000;
        #1 reset = 1'b1;
        step(); step();
        lit("in_reset", 4'b0000, 0, 1'b0);

        reset = 1'b0;
        req   = 4'b0101;
        step(); lit("reset_prio", 4'b0100, 2, 1'b0);
        step(); lit("hold2_c2",   4'b0100, 2, 1'b0);
        step(); lit("hold2_c3",   4'b0100, 2, 1'b0);
        step(); lit("to_of_2",    4'b0000, 0, 1'b1);
        step(); lit("rot_to_0",   4'b0001, 0, 1'b0);
        step(); lit("hold0_c2",   4'b0001, 0, 1'b0);
        step(); lit("hold0_c3",   4'b0001, 0, 1'b0);
        step(); lit("to_of_0",    4'b0000, 0, 1'b1);
        step(); lit("rot_to_2",   4'b0100, 2, 1'b0);
        req = 4'b0000;
        step(); lit("release_2",  4'b0000, 0, 1'b0);

        req = 4'b1000;
        step(); lit("lim_c1",     4'b1000, 3, 1'b0);
        step(); lit("lim_c2",     4'b1000, 3, 1'b0);
        step(); lit("lim_c3",     4'b1000, 3, 1'b0);
        step(); lit("lim_to",     4'b0000, 0, 1'b1);
        step(); lit("lim_regrant",4'b1000, 3, 1'b0);
        req = 4'b0000;
        step(); lit("lim_release",4'b0000, 0, 1'b0);

        req = 4'b0010;
        step(); lit("others_c1",  4'b0010, 1, 1'b0);
        req = 4'b1010;
        step(); lit("others_c2",  4'b0010, 1, 1'b0);
        req = 4'b0011;
        step(); lit("others_c3",  4'b0010, 1, 1'b0);
        req = 4'b0001;
        step(); lit("rel_beats_to", 4'b0000, 0, 1'b0);
        step(); lit("pre_reset",  4'b0001, 0, 1'b0);

        #1 reset = 1'b1;
        req = 4'b1001;
        #1 lit("async_reset", 4'b0000, 0, 1'b0);
        #1 reset = 1'b0;
        step(); lit("post_reset", 4'b1000, 3, 1'b0);

        req = 4'b0000;
        step(); step();

        req = 4'b0100;
        repeat (300) step();
        req = 4'b0000;
        step(); step();

        repeat (10000) begin
            step();
            if ($urandom_range(3) == 0) req = 4'($urandom_range(15));
        end
        req = 4'b0000;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
